// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_ctrl
//  Brief    : Button conditioning, tick prescaler and start/pause/done FSM
//             driving an N-bit countdown timer (tick / load / status).
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       count_zero,
  output logic       tick,
  output logic       load,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PC_W = $clog2(DIV);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PC_W-1:0] PC_MAX = PC_W'(DIV - 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Bit 0 = start button, bit 1 = clear button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_clear, btn_start};

  // --------------------------------------------------------------------------
  // Per-button conditioning: 2-FF synchronizer, debounce, rising-edge pulse.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0]      sync_q, sync_d;
    logic            deb_q, deb_d;
    logic            deb_prev_q, deb_prev_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Debounce: accept the synchronized level only after a full run of
    // consecutive mismatching cycles; any matching cycle restarts the run.
    always_comb begin
      sync_d     = {sync_q[0], btn_raw[i]};
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      cnt_d      = '0;
      if (sync_q[1] != deb_q) begin
        if (cnt_q == DB_MAX) begin
          deb_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Button path registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q     <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync_q     <= sync_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_prev_d;
        cnt_q      <= cnt_d;
      end
    end

    assign press[i] = deb_q & ~deb_prev_q;
  end

  logic p_start;
  logic p_clear;

  assign p_start = press[0];
  assign p_clear = press[1];

  // --------------------------------------------------------------------------
  // FSM, prescaler and registered outputs.
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            tick_q, tick_d;
  logic            load_q, load_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  // Next state, prescaler update and the output values for the next cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tick_d  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p_start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (count_zero) begin
          // Terminal count wins over a pending wrap or pause press.
          state_d = S_DONE;
        end else begin
          if (p_start) begin
            state_d = S_PAUSE;
          end
          if (pc_q == PC_MAX) begin
            // A wrap on the pausing edge is held back so the tick is
            // issued right after resume instead of being lost.
            if (!p_start) begin
              pc_d   = '0;
              tick_d = 1'b1;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (p_start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (p_start) begin
          state_d = S_RUN;
          pc_d    = '0;
          load_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear overrides every other event, including a simultaneous start.
    if (p_clear) begin
      state_d = S_IDLE;
      pc_d    = '0;
      tick_d  = 1'b0;
      load_d  = 1'b1;
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      tick_q    <= 1'b0;
      load_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tick_q    <= tick_d;
      load_q    <= load_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign tick    = tick_q;
  assign load    = load_q;
  assign running = running_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control stage directly upstream of the N-bit countdown timer. Conditions two raw push-buttons (synchronize, debounce, edge-detect), divides the system clock into a one-cycle count-enable `tick`, and runs a start/pause/done state machine that gates those ticks. It issues a `load` pulse that reloads the countdown to 2^N-1. It takes the countdown's zero flag back to stop at terminal count.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `TICK_HZ`, 1, tick rate; DIV = CLK_HZ/TICK_HZ (integer, ≥2).
- `DEBOUNCE_CYCLES`, 500_000, consecutive stable cycles required to accept a button level (≥1).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `btn_start`  in  1  raw start/pause button, active-high, asynchronous to `clk`.
- `btn_clear`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `count_zero`  in  1  high while the downstream countdown value is 0.
- `tick`  out  1  one-cycle count enable to the countdown.
- `load`  out  1  one-cycle synchronous reload request to the countdown.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `state`  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: the debounced level takes the synchronized value after it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle (glitch back) clears the counter.
  - Rising edge of the debounced level gives a one-cycle press pulse (`p_start`, `p_clear`). Release generates nothing.
- Prescaler: counter `pc` in 0..DIV-1.
  - Increments only in RUN and wraps at DIV-1. The wrap produces `tick`.
  - Held in PAUSE.
  - Cleared to 0 on entry to RUN from IDLE or DONE, and on clear.
- FSM (`p_clear` has priority over every other event):
  - any state, `p_clear` → IDLE; `load` pulsed.
  - IDLE, `p_start` → RUN.
  - RUN, `count_zero`=1 → DONE. This takes priority over `p_start`, and no tick is issued in that cycle.
  - RUN, `p_start` → PAUSE.
  - PAUSE, `p_start` → RUN; `pc` resumes from its held value.
  - DONE, `p_start` → RUN; `load` pulsed and `pc` cleared.
- `count_zero` is ignored outside RUN.
- Downstream assumption, fixed by contract: `load` takes effect on the countdown at the same edge that ends the `load` cycle.

## Timing
- All outputs are registered.
- Reset values: `tick`=0, `load`=0, `running`=0, `done`=0, `state`=00. Also `pc`=0, debounced levels=0, debounce counters=0, synchronizers=0.
- Reset asserted mid-operation returns to the reset values asynchronously. The first press after reset release needs full debounce.
- Press latency: a raw button held stable from cycle 0 produces the press pulse in cycle 2+DEBOUNCE_CYCLES (±1). The state changes on the following edge.
- `tick`:
  - First tick is high exactly DIV cycles after `state` becomes RUN from IDLE/DONE, then every DIV cycles while in RUN.
  - Width is exactly 1 cycle.
  - Never high outside RUN.
  - After PAUSE→RUN, the next tick comes after the remaining DIV-1-`pc` cycles.
- `load`:
  - High for exactly 1 cycle, concurrent with the first cycle of the new state (IDLE after clear, RUN after DONE restart).
  - Never coincides with `tick`.
- DONE is entered one edge after `count_zero` is sampled high in RUN.
- Simultaneous `p_start` and `p_clear`: clear wins, `load` pulses, and the start press is discarded.
- Button held continuously: only one press pulse; no auto-repeat.

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), DEBOUNCE_CYCLES=4; `count_zero` driven by the bench.
- Reset asserted mid-cycle with btn_start held → all outputs 0 and `state`=00 immediately, without waiting for a clock edge. After release, holding btn_start for 6 cycles → `state`=01 within 8 cycles.
- IDLE, btn_start pressed → RUN; `tick` high at 10, 20, 30 cycles after entry, each 1 cycle wide.
- 3-cycle btn_start glitch (< DEBOUNCE_CYCLES), then bouncing 1/0/1/0 before a stable hold → no state change from the glitch; exactly one transition from the stable hold.
- RUN, pause at `pc`=6, wait 50 cycles, resume → no tick during PAUSE; the next tick 3 cycles after resume.
- RUN with `count_zero`=1 coinciding with a prescaler wrap → `state`=11, `done`=1, no tick. Then btn_start → `load` for 1 cycle, `state`=01, first tick 10 cycles later.
- btn_start and btn_clear press pulses in the same cycle while in RUN → `state`=00, `load` 1 cycle, no PAUSE entry, `tick` stays 0.
